// File: rtl/nco_quad_freq_meter.sv
// -----------------------------------------------------------------------------
// nco_quad_freq_meter
//
// Receive-side companion to the 1-bit quadrature NCO. The sin/cos pair is
// registered, decoded to a phase quadrant, and compared with the previous
// quadrant to produce a signed step (+1, -1 or 0). Steps are summed in a
// saturating accumulator over a gate window of 2^GATE_BITS enabled clocks.
// At the end of each window the net count is published.
//
// The NCO tuning word can be recovered as:
//   delta_phi ~= quad_count * 2^(PHASE_ACC_BITS-2) / 2^GATE_BITS
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   ena          clock enable; low holds all state, count_valid reads 0
//   clr          synchronous measurement restart (qualified by ena)
//   sin_in       1-bit sine from the NCO
//   cos_in       1-bit cosine from the NCO
//   quad_count   signed net quadrant steps of the last completed window
//   count_valid  one-cycle pulse when quad_count updates
//   skip_err     last window saw at least one two-quadrant jump
//   overflow     last window's accumulator saturated
// -----------------------------------------------------------------------------
module nco_quad_freq_meter #(
    parameter int GATE_BITS  = 10,
    parameter int COUNT_BITS = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic                         clr,
    input  logic                         sin_in,
    input  logic                         cos_in,
    output logic signed [COUNT_BITS-1:0] quad_count,
    output logic                         count_valid,
    output logic                         skip_err,
    output logic                         overflow
);

    localparam logic [GATE_BITS-1:0]         GATE_ONE = {{(GATE_BITS-1){1'b0}}, 1'b1};
    localparam logic signed [COUNT_BITS-1:0] ACC_MAX  = {1'b0, {(COUNT_BITS-1){1'b1}}};
    localparam logic signed [COUNT_BITS-1:0] ACC_MIN  = {1'b1, {(COUNT_BITS-1){1'b0}}};
    localparam logic signed [COUNT_BITS:0]   STEP_P1  = {{COUNT_BITS{1'b0}}, 1'b1};
    localparam logic signed [COUNT_BITS:0]   STEP_M1  = {(COUNT_BITS+1){1'b1}};

    // (sin,cos) -> quadrant: 11->0, 10->1, 00->2, 01->3
    function automatic logic [1:0] quad_of(input logic [1:0] sc);
        logic [1:0] q;
        case (sc)
            2'b11:   q = 2'd0;
            2'b10:   q = 2'd1;
            2'b00:   q = 2'd2;
            default: q = 2'd3;
        endcase
        return q;
    endfunction

    logic [1:0]                   in_q, in_d;
    logic [1:0]                   prev_q, prev_d;
    logic                         prev_valid_q, prev_valid_d;
    logic [GATE_BITS-1:0]         gate_q, gate_d;
    logic signed [COUNT_BITS-1:0] acc_q, acc_d;
    logic                         win_skip_q, win_skip_d;
    logic                         win_ovf_q, win_ovf_d;
    logic signed [COUNT_BITS-1:0] quad_count_q, quad_count_d;
    logic                         count_valid_q, count_valid_d;
    logic                         skip_err_q, skip_err_d;
    logic                         overflow_q, overflow_d;

    logic [1:0]                   q_cur;
    logic [1:0]                   q_diff;
    logic signed [COUNT_BITS:0]   step;
    logic                         skip_now;
    logic signed [COUNT_BITS:0]   sum;
    logic                         sat_now;
    logic signed [COUNT_BITS-1:0] acc_sat;
    logic                         terminal;

    assign q_cur    = quad_of(in_q);
    assign q_diff   = q_cur - prev_q;
    assign terminal = (gate_q == '1);

    always_comb begin
        step     = '0;
        skip_now = 1'b0;
        if (prev_valid_q) begin
            case (q_diff)
                2'd1:    step = STEP_P1;
                2'd3:    step = STEP_M1;
                2'd2:    skip_now = 1'b1;   // half-turn: direction unknown
                default: step = '0;
            endcase
        end
    end

    // One guard bit: steps are only +-1, so a sign/guard disagreement means
    // exactly one LSB past the rail, and the guard bit tells which rail.
    assign sum     = {acc_q[COUNT_BITS-1], acc_q} + step;
    assign sat_now = sum[COUNT_BITS] ^ sum[COUNT_BITS-1];
    assign acc_sat = sat_now ? (sum[COUNT_BITS] ? ACC_MIN : ACC_MAX)
                             : sum[COUNT_BITS-1:0];

    always_comb begin
        in_d          = in_q;
        prev_d        = prev_q;
        prev_valid_d  = prev_valid_q;
        gate_d        = gate_q;
        acc_d         = acc_q;
        win_skip_d    = win_skip_q;
        win_ovf_d     = win_ovf_q;
        quad_count_d  = quad_count_q;
        skip_err_d    = skip_err_q;
        overflow_d    = overflow_q;
        count_valid_d = 1'b0;

        if (ena) begin
            in_d   = {sin_in, cos_in};
            prev_d = q_cur;
            if (clr) begin
                prev_valid_d = 1'b0;
                gate_d       = '0;
                acc_d        = '0;
                win_skip_d   = 1'b0;
                win_ovf_d    = 1'b0;
            end else begin
                prev_valid_d = 1'b1;
                gate_d       = gate_q + GATE_ONE;
                if (terminal) begin
                    quad_count_d  = acc_sat;
                    skip_err_d    = win_skip_q | skip_now;
                    overflow_d    = win_ovf_q | sat_now;
                    count_valid_d = 1'b1;
                    acc_d         = '0;
                    win_skip_d    = 1'b0;
                    win_ovf_d     = 1'b0;
                end else begin
                    acc_d      = acc_sat;
                    win_skip_d = win_skip_q | skip_now;
                    win_ovf_d  = win_ovf_q | sat_now;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q          <= '0;
            prev_q        <= '0;
            prev_valid_q  <= 1'b0;
            gate_q        <= '0;
            acc_q         <= '0;
            win_skip_q    <= 1'b0;
            win_ovf_q     <= 1'b0;
            quad_count_q  <= '0;
            count_valid_q <= 1'b0;
            skip_err_q    <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            in_q          <= in_d;
            prev_q        <= prev_d;
            prev_valid_q  <= prev_valid_d;
            gate_q        <= gate_d;
            acc_q         <= acc_d;
            win_skip_q    <= win_skip_d;
            win_ovf_q     <= win_ovf_d;
            quad_count_q  <= quad_count_d;
            count_valid_q <= count_valid_d;
            skip_err_q    <= skip_err_d;
            overflow_q    <= overflow_d;
        end
    end

    assign quad_count  = quad_count_q;
    assign count_valid = count_valid_q;
    assign skip_err    = skip_err_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_nco_quad_freq_meter.sv
// -----------------------------------------------------------------------------
// tb_nco_quad_freq_meter
//
// Three instances: A (GATE_BITS=4) for rotation, jump, ena, clr and reset
// scenarios; B (GATE_BITS=6, COUNT_BITS=4) for saturation; C (GATE_BITS=10)
// driven by a PHASE_ACC_BITS=10, delta_phi=8 NCO model for loopback.
// -----------------------------------------------------------------------------
module tb_nco_quad_freq_meter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic ena_a, clr_a, sin_a, cos_a, cv_a, sk_a, ov_a;
    logic [11:0] qc_a;
    logic ena_b, clr_b, sin_b, cos_b, cv_b, sk_b, ov_b;
    logic [3:0] qc_b;
    logic ena_c, clr_c, sin_c, cos_c, cv_c, sk_c, ov_c;
    logic [11:0] qc_c;

    nco_quad_freq_meter #(.GATE_BITS(4), .COUNT_BITS(12)) u_a (
        .clk(clk), .rst_n(rst_n), .ena(ena_a), .clr(clr_a),
        .sin_in(sin_a), .cos_in(cos_a), .quad_count(qc_a),
        .count_valid(cv_a), .skip_err(sk_a), .overflow(ov_a));

    nco_quad_freq_meter #(.GATE_BITS(6), .COUNT_BITS(4)) u_b (
        .clk(clk), .rst_n(rst_n), .ena(ena_b), .clr(clr_b),
        .sin_in(sin_b), .cos_in(cos_b), .quad_count(qc_b),
        .count_valid(cv_b), .skip_err(sk_b), .overflow(ov_b));

    nco_quad_freq_meter #(.GATE_BITS(10), .COUNT_BITS(12)) u_c (
        .clk(clk), .rst_n(rst_n), .ena(ena_c), .clr(clr_c),
        .sin_in(sin_c), .cos_in(cos_c), .quad_count(qc_c),
        .count_valid(cv_c), .skip_err(sk_c), .overflow(ov_c));

    int checks = 0;
    int errors = 0;

    logic [1:0] ph_a = 2'd0;
    logic [1:0] ph_b = 2'd0;
    logic [9:0] nco_c = 10'd0;
    int         dir_a = 0;
    int         cnt_a = 0;
    bit         tog_a = 1'b0;
    bit         jump_a = 1'b0;
    bit         run_b = 1'b0;
    bit         run_c = 1'b0;

    bit          seen [3];
    logic [11:0] lq   [3];
    logic        lsk  [3];
    logic        lov  [3];

    function automatic logic [1:0] enc(input logic [1:0] q);
        logic [1:0] sc;
        case (q)
            2'd0:    sc = 2'b11;
            2'd1:    sc = 2'b10;
            2'd2:    sc = 2'b00;
            default: sc = 2'b01;
        endcase
        return sc;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs #1 after the edge, then drive next inputs.
    task automatic cyc();
        logic [1:0] d;
        bit en_was;
        @(posedge clk);
        #1;
        en_was = ena_a;
        if (en_was) begin
            cnt_a++;
            if (dir_a != 0 && (cnt_a % 4) == 0) begin
                d = dir_a[1:0];
                if (jump_a) begin
                    ph_a   = ph_a + 2'd2;
                    jump_a = 1'b0;
                end else begin
                    ph_a = ph_a + d;
                end
            end
        end
        if (tog_a) ena_a = ~ena_a;
        {sin_a, cos_a} = enc(ph_a);
        if (run_b) ph_b = ph_b + 2'd1;
        {sin_b, cos_b} = enc(ph_b);
        if (run_c) nco_c = nco_c + 10'd8;
        sin_c = ~nco_c[9];
        cos_c = ~(nco_c[9] ^ nco_c[8]);
        if (cv_a) begin seen[0] = 1'b1; lq[0] = qc_a;          lsk[0] = sk_a; lov[0] = ov_a; end
        if (cv_b) begin seen[1] = 1'b1; lq[1] = {8'h00, qc_b}; lsk[1] = sk_b; lov[1] = ov_b; end
        if (cv_c) begin seen[2] = 1'b1; lq[2] = qc_c;          lsk[2] = sk_c; lov[2] = ov_c; end
    endtask

    task automatic wait_valid(input int id, input int maxc, output int n);
        seen[id] = 1'b0;
        n = 0;
        while (!seen[id] && n < maxc) begin
            cyc();
            n++;
        end
        chk($sformatf("valid_seen_%0d", id), 32'(seen[id]), 32'd1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        ena_a = 1'b0; clr_a = 1'b0; {sin_a, cos_a} = enc(2'd0);
        ena_b = 1'b0; clr_b = 1'b0; {sin_b, cos_b} = enc(2'd0);
        ena_c = 1'b0; clr_c = 1'b0; sin_c = 1'b1; cos_c = 1'b1;
        repeat (3) cyc();

        chk("rst_qc_a", 32'(qc_a), 32'd0);  chk("rst_cv_a", 32'(cv_a), 32'd0);
        chk("rst_sk_a", 32'(sk_a), 32'd0);  chk("rst_ov_a", 32'(ov_a), 32'd0);
        chk("rst_qc_b", 32'(qc_b), 32'd0);  chk("rst_cv_b", 32'(cv_b), 32'd0);
        chk("rst_sk_b", 32'(sk_b), 32'd0);  chk("rst_ov_b", 32'(ov_b), 32'd0);
        chk("rst_qc_c", 32'(qc_c), 32'd0);  chk("rst_cv_c", 32'(cv_c), 32'd0);
        chk("rst_sk_c", 32'(sk_c), 32'd0);  chk("rst_ov_c", 32'(ov_c), 32'd0);
        rst_n = 1'b1;

        // forward rotation, one quadrant per 4 enabled cycles
        ena_a = 1'b1;
        dir_a = 1;
        wait_valid(0, 100, n);
        chk("first_valid_latency", 32'(n), 32'd16);
        wait_valid(0, 100, n);
        chk("fwd_period", 32'(n), 32'd16);
        chk("fwd_count", 32'(lq[0]), 32'd4);
        chk("fwd_skip", 32'(lsk[0]), 32'd0);
        chk("fwd_ovf", 32'(lov[0]), 32'd0);
        wait_valid(0, 100, n);
        chk("fwd_count2", 32'(lq[0]), 32'd4);

        // reverse rotation
        dir_a = -1;
        wait_valid(0, 100, n);
        wait_valid(0, 100, n);
        chk("rev_count", 32'(lq[0]), 32'h0000_0FFC);
        chk("rev_skip", 32'(lsk[0]), 32'd0);
        chk("rev_ovf", 32'(lov[0]), 32'd0);

        // one illegal 11->00 jump inside a window
        dir_a = 1;
        wait_valid(0, 100, n);
        jump_a = 1'b1;
        wait_valid(0, 100, n);
        chk("jump_count", 32'(lq[0]), 32'd3);
        chk("jump_skip", 32'(lsk[0]), 32'd1);
        wait_valid(0, 100, n);
        chk("after_jump_count", 32'(lq[0]), 32'd4);
        chk("after_jump_skip", 32'(lsk[0]), 32'd0);

        // 50% enable: window doubles in wall clock, count unchanged
        tog_a = 1'b1;
        wait_valid(0, 200, n);
        wait_valid(0, 200, n);
        chk("ena_period", 32'(n), 32'd32);
        chk("ena_count", 32'(lq[0]), 32'd4);
        chk("ena_skip", 32'(lsk[0]), 32'd0);
        tog_a = 1'b0;
        ena_a = 1'b1;
        wait_valid(0, 200, n);

        // clr on the terminal cycle suppresses the pulse and restarts the gate
        repeat (15) cyc();
        clr_a = 1'b1;
        cyc();
        chk("clr_no_valid", 32'(cv_a), 32'd0);
        chk("clr_qc_held", 32'(qc_a), 32'd4);
        clr_a = 1'b0;
        wait_valid(0, 100, n);
        chk("clr_restart_period", 32'(n), 32'd16);
        chk("clr_window_skip", 32'(lsk[0]), 32'd0);

        // asynchronous reset mid-operation while the pulse is high
        rst_n = 1'b0;
        #1;
        chk("midrst_qc", 32'(qc_a), 32'd0);
        chk("midrst_cv", 32'(cv_a), 32'd0);
        chk("midrst_sk", 32'(sk_a), 32'd0);
        chk("midrst_ov", 32'(ov_a), 32'd0);
        repeat (3) cyc();
        rst_n = 1'b1;
        wait_valid(0, 100, n);
        chk("midrst_first_valid", 32'(n), 32'd16);

        // saturation (B) and NCO loopback (C) run together
        ena_a = 1'b0;
        dir_a = 0;
        ena_b = 1'b1; run_b = 1'b1;
        ena_c = 1'b1; run_c = 1'b1;
        wait_valid(1, 200, n);
        chk("sat_first_valid", 32'(n), 32'd64);
        wait_valid(1, 200, n);
        chk("sat_count", 32'(lq[1]), 32'd7);
        chk("sat_ovf", 32'(lov[1]), 32'd1);
        chk("sat_skip", 32'(lsk[1]), 32'd0);

        wait_valid(2, 1100, n);
        wait_valid(2, 1100, n);
        chk("loop_period", 32'(n), 32'd1024);
        chk("loop_count", 32'(lq[2]), 32'd32);
        chk("loop_skip", 32'(lsk[2]), 32'd0);
        chk("loop_ovf", 32'(lov[2]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
